zigzag_stream: RTL and testbench
================================

ZIGZAG_STREAM -- requirements
Module: zigzag_stream

Interface
REQ-001 SHALL have parameter N, default 8, coefficient width in bits.
REQ-002 SHALL have parameter BLK, default 64, coefficients per block; only 64 (8x8) is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  in_data holds a coefficient.
REQ-006 SHALL have port in_ready  output  1  block accepts a coefficient this cycle.
REQ-007 SHALL have port in_data  input  N  coefficient, raster order (forward) or zigzag order (inverse).
REQ-008 SHALL have port mode  input  1  0 = forward (raster->zigzag), 1 = inverse (zigzag->raster).
REQ-009 SHALL have port out_valid  output  1  out_data holds a coefficient.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 SHALL have port out_data  output  N  reordered coefficient.
REQ-012 SHALL have port out_last  output  1  high with the 64th coefficient of a block.

Function
REQ-013 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-014 SHALL hold two 64xN storage banks (ping-pong), each with a full flag, a latched mode bit, a write pointer (wr_bank) and a read pointer (rd_bank).
REQ-015 SHALL use ZZ[k], the standard JPEG zigzag table giving the raster index of the k-th zigzag coefficient: 0,1,8,16,9,2,3,10,17,24,... ending ...,61,54,47,55,62,63.
REQ-016 SHALL drive in_ready = !full[wr_bank].
REQ-017 SHALL keep a 6-bit write counter w.
- Forward: store at raster address w.
- Inverse: store at address ZZ[w].
REQ-018 SHALL latch mode into the bank's mode bit on the handshake where w==0; mode is ignored for the rest of the block.
REQ-019 SHALL, on the handshake with w==63: set full[wr_bank], toggle wr_bank, wrap w to 0.
REQ-020 SHALL drive out_valid = full[rd_bank]; out_data reads combinationally from bank rd_bank with a 6-bit read counter r.
- Forward: read address ZZ[r].
- Inverse: read address r.
REQ-021 SHALL drive out_last = out_valid && r==63; on that handshake, clear full[rd_bank], toggle rd_bank, wrap r to 0.
REQ-022 SHALL make the first coefficient of a block valid on the cycle after its 64th input handshake (latency 1 cycle from block completion).
REQ-023 SHALL sustain one input and one output transfer per cycle with no bubbles at block boundaries when out_ready is held high.
REQ-024 SHALL, when both banks are full, hold in_ready low until the reading bank frees.
- A freeing bank is not writable until the cycle after its clear (no same-cycle bypass).
REQ-025 SHALL hold out_data/out_last stable while out_valid && !out_ready.
REQ-026 SHALL, with in_valid low mid-block, hold w and emit nothing for that block until it completes.

Reset
REQ-027 SHALL, with rst high at a clock edge, clear w, r, wr_bank, rd_bank, both full flags and both mode bits.
REQ-028 SHALL output in_ready=1, out_valid=0, out_last=0 in the cycle after reset.
REQ-029 SHALL discard any partial or pending block on reset mid-operation; bank contents need no reset.

Configuration
REQ-030 SHALL honour mode per REQ-017/018/020 when macro ZIGZAG_STREAM_INV_EN is defined.
REQ-031 SHALL, when ZIGZAG_STREAM_INV_EN is undefined: ignore the mode port, treat all blocks as forward, and remove the inverse address mux and the per-bank mode bits.

Verification
REQ-032 SHALL cover forward mode: input 0..63 raster, out_ready=1 -> outputs 0,1,8,16,9,2,...,62,63; out_last only on 63; first out_valid 1 cycle after input 63.
REQ-033 SHALL cover inverse mode (macro defined): input zigzag sequence 0,1,8,16,... with mode=1 -> outputs 0..63 ascending.
REQ-034 SHALL cover back-to-back blocks: 3 blocks with continuous in_valid and out_ready=1 -> in_ready never drops, 192 outputs with no gaps, out_last on outputs 64, 128, 192.
REQ-035 SHALL cover backpressure: out_ready=0 while feeding 2 full blocks -> in_ready low after 128 accepts, out_data held stable; then out_ready=1 -> in_ready returns 1 cycle after the first out_last.
REQ-036 SHALL cover reset mid-block: assert rst after 30 inputs, then send a fresh 64-coefficient block -> out_valid stays 0 until that block completes, then the output is only the fresh block.
REQ-037 SHALL cover mode latch: mode=1 on coefficient 0, toggled at coefficient 10 (macro defined) -> whole block uses inverse order; without the macro the same stimulus gives forward order.

Source files
------------

// File: rtl/zigzag_stream.sv
// Ping-pong 8x8 zigzag reorder buffer: raster->zigzag (forward) or zigzag->raster (inverse).
// Inverse mode exists only when ZIGZAG_STREAM_INV_EN is defined; otherwise all blocks are forward.
module zigzag_stream #(
   parameter int N   = 8,
   parameter int BLK = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last
);

   localparam logic [5:0] LAST = 6'(BLK - 1);

   // Raster index of the k-th coefficient in JPEG zigzag order.
   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   logic [N-1:0] mem_q [2][BLK];
   logic [5:0]   w_q, w_d, r_q, r_d;
   logic         wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [1:0]   full_q, full_d;
   logic         in_fire, out_fire;
   logic [5:0]   wr_addr, rd_addr;

   assign in_ready  = !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign out_last  = out_valid && (r_q == LAST);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

`ifdef ZIGZAG_STREAM_INV_EN
   logic [1:0] mode_q, mode_d;
   logic       wr_mode;

   // The first coefficient of a block uses the live mode; the rest use the latched copy.
   assign wr_mode = (w_q == 6'd0) ? mode : mode_q[wr_bank_q];
   assign wr_addr = wr_mode ? ZZ[w_q] : w_q;
   assign rd_addr = mode_q[rd_bank_q] ? r_q : ZZ[r_q];

   always_comb begin
      mode_d = mode_q;
      if (in_fire && (w_q == 6'd0))
         mode_d[wr_bank_q] = mode;
   end

   always_ff @(posedge clk) begin
      if (rst) mode_q <= 2'b00;
      else     mode_q <= mode_d;
   end
`else
   logic unused_mode;

   assign unused_mode = mode;
   assign wr_addr     = w_q;
   assign rd_addr     = ZZ[r_q];
`endif

   assign out_data = mem_q[rd_bank_q][rd_addr];

   // Set and clear never hit the same bank in one cycle: set needs it empty, clear needs it full.
   always_comb begin
      w_d       = w_q;
      r_d       = r_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      if (in_fire) begin
         w_d = w_q + 6'd1;
         if (w_q == LAST) begin
            w_d               = 6'd0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end
      end
      if (out_fire) begin
         r_d = r_q + 6'd1;
         if (r_q == LAST) begin
            r_d               = 6'd0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q       <= 6'd0;
         r_q       <= 6'd0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= 2'b00;
      end else begin
         w_q       <= w_d;
         r_q       <= r_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire)
         mem_q[wr_bank_q][wr_addr] <= in_data;
   end

endmodule

// File: tb/tb_zigzag_stream.sv
// Directed bench for zigzag_stream: forward/inverse ordering, streaming, backpressure, reset.
module tb_zigzag_stream;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0, in_ready, mode = 1'b0;
   logic         out_valid, out_ready = 1'b0, out_last;
   logic [N-1:0] in_data = '0, out_data;

   always #5 clk = ~clk;

   zigzag_stream #(.N(N), .BLK(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   int tests = 0, fails = 0;
   int cyc_no = 0, acc = 0, last_acc = -1, stall_in = 0, unstable = 0, smp_cyc = 0;
   logic smp_rdy = 1'b0;
   logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [N-1:0] pd = '0;
   int out_d[$], out_l[$], out_c[$];
   int rdy_c, e;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at the falling edge, then log what transfers at the next rising edge.
   task automatic cyc(input logic iv, input int d, input logic md, input logic ordy);
      @(negedge clk);
      in_valid = iv; in_data = N'(d); mode = md; out_ready = ordy;
      #1;
      smp_cyc = cyc_no; smp_rdy = in_ready;
      if (pv && !pr && out_valid && (out_data !== pd || out_last !== pl)) unstable++;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (in_valid && in_ready) begin acc++; last_acc = cyc_no; end
      if (in_valid && !in_ready) stall_in++;
      if (out_valid && out_ready) begin
         out_d.push_back(int'(out_data));
         out_l.push_back(int'(out_last));
         out_c.push_back(cyc_no);
      end
      cyc_no++;
   endtask

   task automatic clr();
      out_d.delete(); out_l.delete(); out_c.delete();
      acc = 0; last_acc = -1; stall_in = 0; unstable = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; in_data = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      pv = 1'b0;
      clr();
   endtask

   initial begin
      // reset state
      do_reset();
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);

      // forward block, raster 0..63
      for (int t = 0; t < 140; t++) cyc(acc < 64, acc, 1'b0, 1'b1);
      check("fwd_acc", acc, 64);
      check("fwd_cnt", out_d.size(), 64);
      check("fwd_lat", out_c.size() > 0 ? out_c[0] - last_acc : -1, 1);
      for (int k = 0; k < out_d.size() && k < 64; k++) begin
         check("fwd_data", out_d[k], ZZ[k]);
         check("fwd_last", out_l[k], int'(k == 63));
      end

      // three back-to-back blocks
      clr();
      for (int t = 0; t < 192; t++) cyc(1'b1, acc, 1'b0, 1'b1);
      check("b2b_acc", acc, 192);
      check("b2b_in_stall", stall_in, 0);
      for (int t = 0; t < 80; t++) cyc(1'b0, 0, 1'b0, 1'b1);
      check("b2b_cnt", out_d.size(), 192);
      check("b2b_gapless", out_c.size() == 192 ? out_c[191] - out_c[0] : -1, 191);
      for (int k = 0; k < out_d.size() && k < 192; k++) begin
         check("b2b_data", out_d[k], (k / 64) * 64 + ZZ[k % 64]);
         check("b2b_last", out_l[k], int'(k % 64 == 63));
      end

      // backpressure: both banks fill, then drain
      clr();
      for (int t = 0; t < 150; t++) cyc(1'b1, acc, 1'b0, 1'b0);
      check("bp_acc", acc, 128);
      check("bp_in_ready", int'(smp_rdy), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'(out_data), 0);
      check("bp_out_last", int'(out_last), 0);
      check("bp_stable", unstable, 0);
      rdy_c = -1;
      for (int t = 0; t < 140; t++) begin
         cyc(1'b0, 0, 1'b0, 1'b1);
         if (rdy_c < 0 && smp_rdy) rdy_c = smp_cyc;
      end
      check("bp_cnt", out_d.size(), 128);
      check("bp_ready_ret", out_c.size() > 63 ? rdy_c - out_c[63] : -1, 1);
      for (int k = 0; k < out_d.size() && k < 128; k++) begin
         check("bp_data", out_d[k], (k / 64) * 64 + ZZ[k % 64]);
         check("bp_last", out_l[k], int'(k % 64 == 63));
      end

      // reset after 30 coefficients, then a fresh block
      clr();
      for (int t = 0; t < 30; t++) cyc(1'b1, 255 - t, 1'b0, 1'b1);
      check("mr_partial_acc", acc, 30);
      do_reset();
      check("mr_in_ready", int'(in_ready), 1);
      check("mr_out_valid", int'(out_valid), 0);
      for (int t = 0; t < 64; t++) cyc(1'b1, t + 100, 1'b0, 1'b1);
      check("mr_acc", acc, 64);
      check("mr_no_early_out", out_d.size(), 0);
      for (int t = 0; t < 70; t++) cyc(1'b0, 0, 1'b0, 1'b1);
      check("mr_cnt", out_d.size(), 64);
      check("mr_lat", out_c.size() > 0 ? out_c[0] - last_acc : -1, 1);
      for (int k = 0; k < out_d.size() && k < 64; k++)
         check("mr_data", out_d[k], ZZ[k] + 100);

      // mode high on coefficient 0, dropped from coefficient 10; input in zigzag order
      clr();
      for (int t = 0; t < 140; t++)
         cyc(acc < 64, acc < 64 ? ZZ[acc] : 0, acc < 10, 1'b1);
      check("ml_cnt", out_d.size(), 64);
      for (int k = 0; k < out_d.size() && k < 64; k++) begin
`ifdef ZIGZAG_STREAM_INV_EN
         e = k;
`else
         e = ZZ[ZZ[k]];
`endif
         check("ml_data", out_d[k], e);
         check("ml_last", out_l[k], int'(k == 63));
      end

      // forward block following the previous one must not inherit its mode
      clr();
      for (int t = 0; t < 140; t++) cyc(acc < 64, acc, 1'b0, 1'b1);
      check("fwd2_cnt", out_d.size(), 64);
      for (int k = 0; k < out_d.size() && k < 64; k++)
         check("fwd2_data", out_d[k], ZZ[k]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
